// File: rtl/puf_pkg.sv
// Shared types and constants for the arbiter-PUF challenge sequencer.
// Holds the sequencer state encoding and the Galois LFSR feedback masks.
package puf_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_LAUNCH,
    S_SETTLE,
    S_SAMPLE,
    S_NEXT,
    S_DONE
  } state_e;

  // Feedback masks without the implicit x^N term.
  // N=64 uses x^64+x^4+x^3+x+1; N=128 uses x^128+x^7+x^2+x+1.
  localparam logic [127:0] TAPS_64  = 128'h1B;
  localparam logic [127:0] TAPS_128 = 128'h87;

  function automatic logic [127:0] lfsr_taps(input int n);
    return (n == 64) ? TAPS_64 : TAPS_128;
  endfunction

endpackage

// File: rtl/puf_lfsr.sv
// Galois left-shift LFSR that expands a seed into a challenge sequence.
// An all-zero seed is replaced by 1 so the register can never lock up.
module puf_lfsr
  import puf_pkg::*;
#(
  parameter int N = 128
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic [N-1:0] seed,
  output logic [N-1:0] value,
  output logic [N-1:0] next_value
);

  localparam logic [127:0] TAPS_FULL = lfsr_taps(N);
  localparam logic [N-1:0] TAPS      = TAPS_FULL[N-1:0];

  logic [N-1:0] lfsr_q, lfsr_d;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_value = {lfsr_q[N-2:0], 1'b0} ^ (lfsr_q[N-1] ? TAPS : '0);
    lfsr_d     = lfsr_q;
    if (load) begin
      lfsr_d = (seed == '0) ? N'(1) : seed;
    end else if (step) begin
      lfsr_d = next_value;
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= '0;
    else        lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Drives challenge/clear/launch into an arbiter-PUF array, majority-votes the
// synchronized arbiter output per challenge and returns an R-bit response word.
module puf_challenge_sequencer
  import puf_pkg::*;
#(
  parameter int N          = 128,
  parameter int R          = 32,
  parameter int NVOTE      = 3,
  parameter int CLR_CYC    = 2,
  parameter int SETTLE_CYC = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_seed,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [R-1:0] resp_data,
  output logic         busy,
  output logic [N-1:0] puf_sel,
  output logic         puf_in,
  output logic         puf_reset,
  input  logic         puf_out
);

  localparam int VOTE_W  = $clog2(NVOTE + 1);
  localparam int IDX_W   = $clog2(R);
  localparam int CYC_MAX = (CLR_CYC > SETTLE_CYC) ? CLR_CYC : SETTLE_CYC;
  localparam int CYC_W   = $clog2(CYC_MAX);

  localparam logic [CYC_W-1:0]  CLR_LOAD    = CYC_W'(CLR_CYC - 1);
  localparam logic [CYC_W-1:0]  SETTLE_LOAD = CYC_W'(SETTLE_CYC - 1);
  localparam logic [VOTE_W-1:0] VOTE_ALL    = VOTE_W'(NVOTE);
  localparam logic [VOTE_W-1:0] VOTE_HALF   = VOTE_W'(NVOTE / 2);
  localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(R - 1);

  state_e              state_q, state_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [VOTE_W-1:0]   evals_q, evals_d;
  logic [VOTE_W-1:0]   ones_q, ones_d;
  logic [R-1:0]        resp_q, resp_d;
  logic [N-1:0]        puf_sel_q, puf_sel_d;
  logic                puf_in_q, puf_in_d;
  logic                puf_reset_q, puf_reset_d;
  logic [1:0]          sync_q, sync_d;

  logic                lfsr_load, lfsr_step;
  logic [N-1:0]        lfsr_value, lfsr_next;

  puf_lfsr #(.N(N)) u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .load       (lfsr_load),
    .step       (lfsr_step),
    .seed       (req_seed),
    .value      (lfsr_value),
    .next_value (lfsr_next)
  );

  // puf_out is asynchronous; only the second synchronizer stage is consumed.
  assign sync_d = {sync_q[0], puf_out};

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    idx_d     = idx_q;
    evals_d   = evals_q;
    ones_d    = ones_q;
    resp_d    = resp_q;
    puf_sel_d = puf_sel_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          lfsr_load = 1'b1;
          resp_d    = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        idx_d     = '0;
        evals_d   = '0;
        ones_d    = '0;
        cyc_d     = CLR_LOAD;
        puf_sel_d = lfsr_value;
        state_d   = S_CLEAR;
      end
      S_CLEAR: begin
        if (cyc_q == '0) state_d = S_LAUNCH;
        else             cyc_d   = cyc_q - CYC_W'(1);
      end
      S_LAUNCH: begin
        cyc_d   = SETTLE_LOAD;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cyc_q == '0) state_d = S_SAMPLE;
        else             cyc_d   = cyc_q - CYC_W'(1);
      end
      S_SAMPLE: begin
        ones_d  = ones_q + VOTE_W'(sync_q[1]);
        evals_d = evals_q + VOTE_W'(1);
        if (evals_d < VOTE_ALL) begin
          cyc_d   = CLR_LOAD;
          state_d = S_CLEAR;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        resp_d[idx_q] = (ones_q > VOTE_HALF);
        lfsr_step     = 1'b1;
        evals_d       = '0;
        ones_d        = '0;
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d     = idx_q + IDX_W'(1);
          cyc_d     = CLR_LOAD;
          puf_sel_d = lfsr_next;
          state_d   = S_CLEAR;
        end
      end
      S_DONE: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Drive the PUF pins from the state being entered so they are registered.
    puf_in_d    = (state_d == S_LAUNCH) || (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    puf_reset_d = !puf_in_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cyc_q       <= '0;
      idx_q       <= '0;
      evals_q     <= '0;
      ones_q      <= '0;
      resp_q      <= '0;
      puf_sel_q   <= '0;
      puf_in_q    <= 1'b0;
      puf_reset_q <= 1'b1;
      sync_q      <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      idx_q       <= idx_d;
      evals_q     <= evals_d;
      ones_q      <= ones_d;
      resp_q      <= resp_d;
      puf_sel_q   <= puf_sel_d;
      puf_in_q    <= puf_in_d;
      puf_reset_q <= puf_reset_d;
      sync_q      <= sync_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_DONE);
  assign resp_data  = resp_q;
  assign puf_sel    = puf_sel_q;
  assign puf_in     = puf_in_q;
  assign puf_reset  = puf_reset_q;

endmodule
